probe_buffer_mc: RTL and testbench

- Multi-channel, parametrised probe capture buffer; successor to the single-register 64-bit probe buffer.
- Each channel holds a DEPTH-entry circular FIFO of probe samples, selectable drop-on-full or overwrite-oldest mode, and a sticky overflow flag.
- Contents are drained through a magic-device-style select/ready/valid read port, so simulation harnesses and debug firmware can stream probe history rather than see only the last value.

---
 rtl/probe_buffer_mc.sv | 131 +++++++++++++
 tb/tb_probe_buffer_mc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/probe_buffer_mc.sv
// Multi-channel probe capture buffer: one circular FIFO per channel, drained
// through a select/ready/valid read port with one-cycle response latency.
module probe_buffer_mc #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned OVERWRITE = 0,
  parameter int unsigned SEL_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] write,
  input  logic [CHANNELS-1:0]       wen,
  output logic [CHANNELS*WIDTH-1:0] latest,
  output logic [CHANNELS-1:0]       not_empty,
  input  logic [SEL_WIDTH-1:0]      read_select,
  input  logic                      read_ready,
  output logic                      read_valid,
  output logic [WIDTH-1:0]          read_data
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [3:0] OP_POP    = 4'd0;
  localparam logic [3:0] OP_COUNT  = 4'd1;
  localparam logic [3:0] OP_STATUS = 4'd2;

  logic [3:0]      op;
  logic [7:0]      ch;
  logic            ch_ok;
  logic [CH_W-1:0] idx;

  assign op    = read_select[11:8];
  assign ch    = read_select[7:0];
  assign ch_ok = 32'(ch) < CHANNELS;
  assign idx   = ch[CH_W-1:0];

  if (SEL_WIDTH > 12) begin : g_sel_hi
    logic unused_sel_hi;
    assign unused_sel_hi = ^read_select[SEL_WIDTH-1:12];
  end

  logic [CW-1:0]    cnt  [CHANNELS];
  logic             ovfs [CHANNELS];
  logic [WIDTH-1:0] head [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             ovf;
    logic [WIDTH-1:0] latest_q;
    logic             ne_q;
    logic [WIDTH-1:0] sample;
    logic             sel, full, pop, stat, push, grow, ovf_set, store, adv_rd;

    assign sample  = write[i*WIDTH +: WIDTH];
    assign sel     = read_ready && ch_ok && (idx == CH_W'(i));
    assign full    = (count == CW'(DEPTH));
    assign pop     = sel && (op == OP_POP) && (count != '0);
    assign stat    = sel && (op == OP_STATUS);
    assign push    = wen[i];
    // A same-cycle pop frees a slot, so a full channel still accepts the push.
    assign grow    = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign store   = grow || (ovf_set && (OVERWRITE != 0));
    assign adv_rd  = pop || (ovf_set && (OVERWRITE != 0));

    assign count_next = count + CW'(grow) - CW'(pop);

    always_ff @(posedge clock) begin
      if (store) mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        ovf      <= 1'b0;
        latest_q <= '0;
        ne_q     <= 1'b0;
      end else begin
        if (push) latest_q <= sample;
        if (store) wr_ptr <= wr_ptr + PW'(1);
        if (adv_rd) rd_ptr <= rd_ptr + PW'(1);
        count <= count_next;
        ne_q  <= (count_next != '0);
        // Overflow set wins over a same-cycle STATUS clear.
        if (ovf_set) ovf <= 1'b1;
        else if (stat) ovf <= 1'b0;
      end
    end

    assign latest[i*WIDTH +: WIDTH] = latest_q;
    assign not_empty[i]             = ne_q;
    assign cnt[i]                   = count;
    assign ovfs[i]                  = ovf;
    assign head[i]                  = mem[rd_ptr];
  end

  logic [WIDTH-1:0] rsp;

  // Response payload for the currently selected channel/op.
  always_comb begin
    rsp = '0;
    if (ch_ok) begin
      case (op)
        OP_POP:    if (cnt[idx] != '0) rsp = head[idx];
        OP_COUNT:  rsp = WIDTH'(cnt[idx]);
        OP_STATUS: rsp[2:0] = {cnt[idx] == '0, cnt[idx] == CW'(DEPTH), ovfs[idx]};
        default:   rsp = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= read_ready;
      read_data  <= read_ready ? rsp : '0;
    end
  end

endmodule

// File: tb/tb_probe_buffer_mc.sv
// Directed scoreboard bench for probe_buffer_mc; two instances (drop and
// overwrite modes) share stimulus and are checked against separate queues.
module tb_probe_buffer_mc;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned BW = C * W;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] write = '0;
  logic [C-1:0]  wen = '0;
  logic [11:0]   read_select = '0;
  logic          read_ready = 1'b0;

  logic [BW-1:0] lat0, lat1;
  logic [C-1:0]  ne0, ne1;
  logic          rv0, rv1;
  logic [W-1:0]  rd0, rd1;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  probe_buffer_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .OVERWRITE(0), .SEL_WIDTH(12)) u0 (
    .clock(clock), .reset(reset), .write(write), .wen(wen), .latest(lat0),
    .not_empty(ne0), .read_select(read_select), .read_ready(read_ready),
    .read_valid(rv0), .read_data(rd0));

  probe_buffer_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .OVERWRITE(1), .SEL_WIDTH(12)) u1 (
    .clock(clock), .reset(reset), .write(write), .wen(wen), .latest(lat1),
    .not_empty(ne1), .read_select(read_select), .read_ready(read_ready),
    .read_valid(rv1), .read_data(rd1));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance one edge; a request presented before the edge must answer right after it.
  task automatic step();
    logic         rq;
    logic [W-1:0] e0, e1;
    rq = read_ready;
    @(posedge clock);
    #1;
    chk("valid_u0", BW'(rv0), BW'(rq));
    chk("valid_u1", BW'(rv1), BW'(rq));
    if (rq) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("data_u0", BW'(rd0), BW'(e0));
      chk("data_u1", BW'(rd1), BW'(e1));
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [7:0] ch,
                     input logic [W-1:0] e0, input logic [W-1:0] e1);
    read_select = {op, ch};
    read_ready  = 1'b1;
    q0.push_back(e0);
    q1.push_back(e1);
    step();
  endtask

  task automatic done();
    read_ready = 1'b0;
    wen        = '0;
  endtask

  task automatic push(input int ch, input logic [W-1:0] v);
    read_ready      = 1'b0;
    wen             = C'(1) << ch;
    write[ch*W +: W] = v;
    step();
    wen = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_latest_u0", lat0, '0);
    chk("rst_latest_u1", lat1, '0);
    chk("rst_ne_u0", BW'(ne0), '0);
    chk("rst_valid_u0", BW'(rv0), '0);
    chk("rst_data_u0", BW'(rd0), '0);
    reset = 1'b1;

    // Basic push/pop on ch1, back-to-back pops
    push(1, 64'hA1);
    chk("ne1_after_push", BW'(ne0[1]), BW'(1'b1));
    push(1, 64'hA2);
    push(1, 64'hA3);
    req(4'd0, 8'd1, 64'hA1, 64'hA1);
    req(4'd0, 8'd1, 64'hA2, 64'hA2);
    req(4'd0, 8'd1, 64'hA3, 64'hA3);
    chk("ne1_drained_u0", BW'(ne0[1]), '0);
    chk("ne1_drained_u1", BW'(ne1[1]), '0);
    req(4'd0, 8'd1, 64'h0, 64'h0);
    done();
    chk("latest1_u0", BW'(lat0[1*W +: W]), BW'(64'hA3));

    // Overflow: drop vs overwrite on ch0
    for (int k = 1; k <= 6; k++) push(0, W'(k));
    req(4'd1, 8'd0, 64'd4, 64'd4);
    req(4'd2, 8'd0, 64'h3, 64'h3);
    req(4'd2, 8'd0, 64'h2, 64'h2);
    req(4'd0, 8'd0, 64'd1, 64'd3);
    req(4'd0, 8'd0, 64'd2, 64'd4);
    req(4'd0, 8'd0, 64'd3, 64'd5);
    req(4'd0, 8'd0, 64'd4, 64'd6);
    done();
    chk("latest0_u0", BW'(lat0[0 +: W]), BW'(64'd6));
    chk("latest0_u1", BW'(lat1[0 +: W]), BW'(64'd6));

    // Full ch2: push and pop in the same cycle
    for (int k = 0; k < 4; k++) push(2, W'(64'h71 + k));
    wen = 4'b0100;
    write[2*W +: W] = 64'h77;
    req(4'd0, 8'd2, 64'h71, 64'h71);
    wen = '0;
    req(4'd1, 8'd2, 64'd4, 64'd4);
    req(4'd2, 8'd2, 64'h2, 64'h2);
    req(4'd0, 8'd2, 64'h72, 64'h72);
    req(4'd0, 8'd2, 64'h73, 64'h73);
    req(4'd0, 8'd2, 64'h74, 64'h74);
    req(4'd0, 8'd2, 64'h77, 64'h77);
    done();

    // Out-of-range channel and unused op
    push(3, 64'h55);
    req(4'd0, 8'hFF, 64'h0, 64'h0);
    req(4'd5, 8'd0, 64'h0, 64'h0);
    req(4'd1, 8'd3, 64'd1, 64'd1);
    done();
    chk("ne_after_bad_ops", BW'(ne0), BW'(4'b1000));

    // STATUS clear colliding with an overflow on ch3: set wins
    push(3, 64'h56);
    push(3, 64'h57);
    push(3, 64'h58);
    wen = 4'b1000;
    write[3*W +: W] = 64'h59;
    req(4'd2, 8'd3, 64'h2, 64'h2);
    wen = '0;
    req(4'd2, 8'd3, 64'h3, 64'h3);
    done();

    // Reset between a POP request and its response edge
    read_select = {4'd0, 8'd3};
    read_ready  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("arst_latest_u0", lat0, '0);
    chk("arst_latest_u1", lat1, '0);
    chk("arst_ne_u0", BW'(ne0), '0);
    chk("arst_data_u0", BW'(rd0), '0);
    chk("arst_valid_u1", BW'(rv1), '0);
    @(posedge clock);
    #1;
    chk("arst_novalid_u0", BW'(rv0), '0);
    chk("arst_novalid_u1", BW'(rv1), '0);
    read_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) req(4'd1, 8'(k), 64'd0, 64'd0);
    done();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
